// File: rtl/fpu_ctrl_pkg.sv
// fpu_ctrl_pkg
//   Shared constants for the FP issue sequencer and any unit that decodes FP
//   ops (e.g. the hazard unit): FP op codes as produced by alu_controller and
//   the 2-bit sequencer state encoding.
package fpu_ctrl_pkg;

  // FP op codes; bit 4 set marks an FP op.
  localparam logic [4:0] OP_FADD  = 5'b10000;
  localparam logic [4:0] OP_FSUB  = 5'b10001;
  localparam logic [4:0] OP_FMUL  = 5'b10010;
  localparam logic [4:0] OP_FDIV  = 5'b10011;
  localparam logic [4:0] OP_FSQRT = 5'b11011;

  // Sequencer state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/fpu_latency_lut.sv
// fpu_latency_lut
//   Combinational op -> (latency - 1) lookup. The value is what the sequencer
//   loads into its down-counter on accept, so an op with latency N spends
//   exactly N cycles in BUSY. Codes with bit 4 set that are not listed fall
//   back to LAT_DEFAULT.
// Ports
//   op      in  5      op code
//   lat_m1  out CNT_W  latency minus one
module fpu_latency_lut
  import fpu_ctrl_pkg::*;
#(
  parameter int LAT_FADD    = 3,
  parameter int LAT_FMUL    = 2,
  parameter int LAT_FDIV    = 10,
  parameter int LAT_FSQRT   = 12,
  parameter int LAT_DEFAULT = 1,
  parameter int CNT_W       = 4
) (
  input  logic [4:0]       op,
  output logic [CNT_W-1:0] lat_m1
);

  // Each latency must be representable as (LAT-1) in CNT_W bits and be >= 1.
  localparam int LAT_MAX = 2 ** CNT_W;

  if (LAT_FADD < 1 || LAT_FADD > LAT_MAX ||
      LAT_FMUL < 1 || LAT_FMUL > LAT_MAX ||
      LAT_FDIV < 1 || LAT_FDIV > LAT_MAX ||
      LAT_FSQRT < 1 || LAT_FSQRT > LAT_MAX ||
      LAT_DEFAULT < 1 || LAT_DEFAULT > LAT_MAX) begin : g_bad_lat
    $error("fpu_latency_lut: every LAT_* must lie in 1..2**CNT_W");
  end

  always_comb begin
    lat_m1 = CNT_W'(LAT_DEFAULT - 1);
    case (op)
      OP_FADD, OP_FSUB: lat_m1 = CNT_W'(LAT_FADD - 1);
      OP_FMUL:          lat_m1 = CNT_W'(LAT_FMUL - 1);
      OP_FDIV:          lat_m1 = CNT_W'(LAT_FDIV - 1);
      OP_FSQRT:         lat_m1 = CNT_W'(LAT_FSQRT - 1);
      default:          lat_m1 = CNT_W'(LAT_DEFAULT - 1);
    endcase
  end

endmodule

// File: rtl/fpu_issue_sequencer.sv
// fpu_issue_sequencer
//   Sequences one multi-cycle FP op at a time in EX. An FP op is accepted from
//   IDLE, launched to the FPU with a one-cycle fu_start pulse, held in BUSY for
//   its latency while stall freezes IF/ID/EX, then presented for one DONE cycle
//   with result_valid. Integer ops pass straight through: never stalled,
//   never launched.
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   issue_valid    EX holds a valid instruction
//   alu_control    op code (bit 4 = FP)
//   src_a, src_b   operands, latched on accept
//   flush          squash EX; aborts an op in BUSY
//   stall          hold IF/ID/EX
//   fu_start       one-cycle launch pulse; fu_op/fu_a/fu_b hold the launched op
//   fu_abort       one-cycle cancel pulse after a flush in BUSY
//   fu_result      FPU result, sampled on the final BUSY cycle
//   result_valid   one-cycle strobe during DONE
//   result         last captured FP result, held until the next capture
//
// Issue handshake: an FP op is taken on a clock edge where the sequencer is
// IDLE, issue_valid & alu_control[4] is high and flush is low. stall is high
// for that cycle and for every BUSY cycle, so EX keeps presenting the same
// instruction; it drops in DONE so EX retires together with result_valid.
module fpu_issue_sequencer
  import fpu_ctrl_pkg::*;
#(
  parameter int LAT_FADD    = 3,
  parameter int LAT_FMUL    = 2,
  parameter int LAT_FDIV    = 10,
  parameter int LAT_FSQRT   = 12,
  parameter int LAT_DEFAULT = 1,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [4:0]  alu_control,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        fu_start,
  output logic [4:0]  fu_op,
  output logic [31:0] fu_a,
  output logic [31:0] fu_b,
  output logic        fu_abort,
  input  logic [31:0] fu_result,
  output logic        result_valid,
  output logic [31:0] result
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lat_m1;
  logic             fp_req;
  logic             accept;

  assign fp_req = issue_valid & alu_control[4];
  assign accept = (state == ST_IDLE) & fp_req & ~flush;
  assign stall  = accept | (state == ST_BUSY);

  fpu_latency_lut #(
    .LAT_FADD   (LAT_FADD),
    .LAT_FMUL   (LAT_FMUL),
    .LAT_FDIV   (LAT_FDIV),
    .LAT_FSQRT  (LAT_FSQRT),
    .LAT_DEFAULT(LAT_DEFAULT),
    .CNT_W      (CNT_W)
  ) u_lut (
    .op    (alu_control),
    .lat_m1(lat_m1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      fu_start     <= 1'b0;
      fu_op        <= '0;
      fu_a         <= '0;
      fu_b         <= '0;
      fu_abort     <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
    end else begin
      // Pulses default low; each is raised for exactly one cycle below.
      fu_start     <= 1'b0;
      fu_abort     <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_BUSY;
            fu_op    <= alu_control;
            fu_a     <= src_a;
            fu_b     <= src_b;
            cnt      <= lat_m1;
            fu_start <= 1'b1;
          end
        end
        ST_BUSY: begin
          // A flush on the final BUSY cycle still aborts: no result escapes.
          if (flush) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            fu_abort <= 1'b1;
          end else if (cnt == '0) begin
            state        <= ST_DONE;
            result       <= fu_result;
            result_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          // Never re-accept here; a held FP request is taken from IDLE.
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
module tb_fpu_issue_sequencer;
  import fpu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  alu_control = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic        fu_start;
  logic [4:0]  fu_op;
  logic [31:0] fu_a;
  logic [31:0] fu_b;
  logic        fu_abort;
  logic [31:0] fu_result = '0;
  logic        result_valid;
  logic [31:0] result;

  fpu_issue_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .flush       (flush),
    .stall       (stall),
    .fu_start    (fu_start),
    .fu_op       (fu_op),
    .fu_a        (fu_a),
    .fu_b        (fu_b),
    .fu_abort    (fu_abort),
    .fu_result   (fu_result),
    .result_valid(result_valid),
    .result      (result)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];      // expected result per result_valid pulse
  logic [68:0] launch_q[$];   // expected {op, a, b} per fu_start pulse
  logic [31:0] last_res = '0; // value result must hold between captures

  int start_cnt   = 0;
  int abort_cnt   = 0;
  int rv_cnt      = 0;
  int rv_last_cyc = 0;
  int rv_prev_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops and compares whenever the DUT presents a launch or result.
  initial forever begin
    logic [68:0] l;
    logic [31:0] r;
    @(negedge clk);
    if (!rst) begin
      if (fu_start) begin
        start_cnt++;
        if (launch_q.size() == 0) begin
          check("unexpected fu_start", 32'd1, 32'd0);
        end else begin
          l = launch_q.pop_front();
          check("fu_op", 32'(fu_op), 32'(l[68:64]));
          check("fu_a", fu_a, l[63:32]);
          check("fu_b", fu_b, l[31:0]);
        end
      end
      if (fu_abort) abort_cnt++;
      if (result_valid) begin
        rv_cnt++;
        rv_prev_cyc = rv_last_cyc;
        rv_last_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected result_valid", 32'd1, 32'd0);
        end else begin
          r = exp_q.pop_front();
          check("result", result, r);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one FP op and walk it through BUSY. flush_on = 0 lets it complete;
  // otherwise flush is raised during that (1-based) BUSY cycle.
  task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r, input int lat,
                       input int flush_on);
    int s0, rv0, ab0, c0;
    s0  = start_cnt;
    rv0 = rv_cnt;
    ab0 = abort_cnt;
    issue_valid = 1'b1;
    alu_control = op;
    src_a       = a;
    src_b       = b;
    fu_result   = r;
    flush       = 1'b0;
    launch_q.push_back({op, a, b});
    if (flush_on == 0) exp_q.push_back(r);
    @(negedge clk);
    check({tag, " accept stall"}, 32'(stall), 32'd1);
    next_cycle();
    c0 = cyc;
    issue_valid = 1'b0;
    alu_control = '0;
    for (int i = 1; i <= lat; i++) begin
      if (i == flush_on) flush = 1'b1;
      @(negedge clk);
      check({tag, " busy stall"}, 32'(stall), 32'd1);
      next_cycle();
      flush = 1'b0;
      if (i == flush_on) break;
    end
    @(negedge clk);
    if (flush_on != 0) begin
      check({tag, " abort pulse"}, 32'(fu_abort), 32'd1);
      check({tag, " abort stall"}, 32'(stall), 32'd0);
      check({tag, " result held"}, result, last_res);
    end else begin
      check({tag, " done stall"}, 32'(stall), 32'd0);
      last_res = r;
    end
    next_cycle();
    check({tag, " start count"}, 32'(start_cnt - s0), 32'd1);
    check({tag, " rv count"}, 32'(rv_cnt - rv0), (flush_on != 0) ? 32'd0 : 32'd1);
    check({tag, " abort count"}, 32'(abort_cnt - ab0), (flush_on != 0) ? 32'd1 : 32'd0);
    if (flush_on == 0) check({tag, " latency"}, 32'(rv_last_cyc - c0), 32'(lat));
    @(negedge clk);
    check({tag, " idle result"}, result, last_res);
    next_cycle();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int s0, rv0, ab0, c0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst stall", 32'(stall), 32'd0);
    check("rst fu_start", 32'(fu_start), 32'd0);
    check("rst fu_abort", 32'(fu_abort), 32'd0);
    check("rst result_valid", 32'(result_valid), 32'd0);
    check("rst result", result, 32'd0);
    check("rst fu_op", 32'(fu_op), 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Integer op held 5 cycles: never stalls, never launches.
    s0 = start_cnt;
    issue_valid = 1'b1;
    alu_control = 5'b00010;
    src_a = 32'h1234_5678;
    src_b = 32'h0000_0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("int stall", 32'(stall), 32'd0);
      next_cycle();
    end
    issue_valid = 1'b0;
    check("int no start", 32'(start_cnt - s0), 32'd0);

    // fmul 1.5 * 2.0 = 3.0; latency 2 (result 2 cycles after accept edge)
    do_op("fmul", OP_FMUL, 32'h3fc0_0000, 32'h4000_0000, 32'h4040_0000, 2, 0);

    // fsub and an unknown FP code (default latency 1)
    do_op("fsub", OP_FSUB, 32'h4100_0000, 32'h3f80_0000, 32'h40e0_0000, 3, 0);
    do_op("dflt", 5'b10100, 32'hdead_beef, 32'h0bad_f00d, 32'h1357_9bdf, 1, 0);

    // fdiv flushed on its 4th BUSY cycle, then an fadd goes through.
    do_op("fdiv flush", OP_FDIV, 32'h4120_0000, 32'h4000_0000, 32'h40a0_0000, 10, 4);
    do_op("fadd", OP_FADD, 32'h3f80_0000, 32'h3f80_0000, 32'h4000_0000, 3, 0);

    // fsqrt flushed on its final BUSY cycle: abort wins, result unchanged.
    do_op("fsqrt flush", OP_FSQRT, 32'h4180_0000, 32'h0, 32'h4080_0000, 12, 12);

    // flush while IDLE with an FP request: not accepted, no abort.
    s0  = start_cnt;
    ab0 = abort_cnt;
    issue_valid = 1'b1;
    alu_control = OP_FMUL;
    flush = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("idle flush stall", 32'(stall), 32'd0);
      next_cycle();
    end
    issue_valid = 1'b0;
    flush = 1'b0;
    next_cycle();
    check("idle flush no start", 32'(start_cnt - s0), 32'd0);
    check("idle flush no abort", 32'(abort_cnt - ab0), 32'd0);

    // Back-to-back fadd with issue_valid held. First op: BUSY 3, DONE 1,
    // then one IDLE cycle where the held request is re-accepted, BUSY 3, DONE.
    // Results appear 3 and 8 cycles after the first accept edge.
    s0  = start_cnt;
    rv0 = rv_cnt;
    issue_valid = 1'b1;
    alu_control = OP_FADD;
    src_a = 32'h4000_0000;
    src_b = 32'h4040_0000;
    fu_result = 32'h40a0_0000;
    launch_q.push_back({OP_FADD, 32'h4000_0000, 32'h4040_0000});
    launch_q.push_back({OP_FADD, 32'h4000_0000, 32'h4040_0000});
    exp_q.push_back(32'h40a0_0000);
    exp_q.push_back(32'h40c0_0000);
    next_cycle();
    c0 = cyc;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 3) check("b2b done no reaccept", 32'(stall), 32'd0);
      if (k == 4) check("b2b idle reaccept", 32'(stall), 32'd1);
      next_cycle();
      if (k == 3) fu_result = 32'h40c0_0000;
      if (k == 4) issue_valid = 1'b0;
    end
    last_res = 32'h40c0_0000;
    check("b2b rv pulses", 32'(rv_cnt - rv0), 32'd2);
    check("b2b starts", 32'(start_cnt - s0), 32'd2);
    check("b2b first rv", 32'(rv_prev_cyc - c0), 32'd3);
    check("b2b second rv", 32'(rv_last_cyc - c0), 32'd8);
    check("b2b result held", result, last_res);

    // Reset mid-BUSY: immediate IDLE, no result or abort emitted.
    rv0 = rv_cnt;
    ab0 = abort_cnt;
    issue_valid = 1'b1;
    alu_control = OP_FDIV;
    src_a = 32'h3f80_0000;
    src_b = 32'h4040_0000;
    fu_result = 32'h3eaa_aaab;
    launch_q.push_back({OP_FDIV, 32'h3f80_0000, 32'h4040_0000});
    next_cycle();
    issue_valid = 1'b0;
    repeat (3) next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("midop rst state", 32'(dut.state), 32'(ST_IDLE));
    check("midop rst stall", 32'(stall), 32'd0);
    check("midop rst result_valid", 32'(result_valid), 32'd0);
    check("midop rst fu_start", 32'(fu_start), 32'd0);
    check("midop rst fu_abort", 32'(fu_abort), 32'd0);
    last_res = '0;
    next_cycle();
    rst = 1'b0;
    repeat (15) next_cycle();
    check("midop rst no rv", 32'(rv_cnt - rv0), 32'd0);
    check("midop rst no abort", 32'(abort_cnt - ab0), 32'd0);
    check("midop rst stall after", 32'(stall), 32'd0);
    check("midop rst result", result, last_res);

    // Everything expected must have been seen.
    check("exp_q drained", 32'(exp_q.size()), 32'd0);
    check("launch_q drained", 32'(launch_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
